disp_write_sched: RTL
=====================

Name: disp_write_sched

Overview:
- Scheduler that shares the 4-digit multiplexed 7-segment display write port between two byte producers.
- Requester 0 is the keyboard scancode path and owns digits 1:0; requester 1 is the ASCII/character path and owns digits 3:2.
- Each accepted byte is split into two nibble writes (low nibble, then high nibble), driven as load / bufdestino / nible into the hex-to-7seg converter and the display mux.
- Sits between the producers and the display4mux load interface.

Parameters:
- WR_GAP, 1, idle cycles (load=0) after each nibble write; legal range 0..15.

Ports:
- reloj  input  1  system clock, 50 MHz
- reset  input  1  reset, synchronous, active-high
- req0  input  1  requester 0 write request (level)
- byte0  input  8  requester 0 data; sampled at grant
- ack0  output  1  one-cycle pulse: requester 0 byte accepted
- req1  input  1  requester 1 write request (level)
- byte1  input  8  requester 1 data; sampled at grant
- ack1  output  1  one-cycle pulse: requester 1 byte accepted
- load  output  1  display buffer load strobe, one cycle per nibble
- bufdestino  output  2  destination digit 0..3
- nible  output  4  hex digit to write
- busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: load=0, bufdestino=0, nible=0, ack0=ack1=0, busy=0, state=IDLE, last_grant=1, so req0 wins the first tie.
- Reset mid-sequence aborts it immediately. The remaining nibble is not written, and no ack is issued in the reset cycle.
- States: IDLE, WR_LO, GAP_LO, WR_HI, GAP_HI.
- IDLE, no req: outputs load=0, ack=0.
- IDLE, req sampled at cycle 0:
  - Grant goes to the single requester, or, if both request, to the one != last_grant.
  - Latch the byte and grant id, update last_grant, go to WR_LO.
- WR_LO, cycle 1: load=1, bufdestino=base, nible=byte[3:0], ack of the granted requester=1.
  - base = 0 for req0, 2 for req1.
- GAP_LO: WR_GAP cycles of load=0. Skipped when WR_GAP=0.
- WR_HI, cycle 2+WR_GAP: load=1, bufdestino=base+1, nible=byte[7:4].
- GAP_HI: WR_GAP cycles of load=0, then IDLE. With WR_GAP=0, go directly to IDLE.
- Request rate: the earliest next grant is sampled in the IDLE cycle, so back-to-back requests produce a load every 2+2*WR_GAP+1 cycles per byte, including the IDLE cycle.
- Handshake: the requester holds req and byte stable until it sees ack, then drops req. Req still high in IDLE after ack is treated as a new request.
- Byte changes after grant are ignored.
- bufdestino and nible hold their last values while load=0.
- The gap counter is 4 bits, reloaded with WR_GAP on entry to each gap state, and counts down to 0.
- Same-cycle req from both requesters with last_grant=0 grants req1. Alternation is strict round-robin.

Optional Feature:
- Macro: DISP_CLEAR_ON_RESET_EN.
- With it defined:
  - After reset deasserts, the block passes through CLR states writing nible=0 to digits 0,1,2,3 in order.
  - Each write is a one-cycle load with WR_GAP idle cycles after it.
  - busy=1 throughout; requests are held off with no ack until the block enters IDLE.
- Without it: the block enters IDLE directly after reset, and display contents are left to the display mux reset.

Decomposition:
- Shared package / include `disp_pkg`:
  - state encodings;
  - digit base constants DIG_KEYB=2'd0, DIG_ASCII=2'd2;
  - NIB_W=4, DIG_W=2.
- Sub-module `rr_arb2`: two-input round-robin arbiter holding last_grant, with grant valid and update strobe. Everything else stays in one module.

Test Plan:
- req0, byte0=8'h1C, WR_GAP=1, idle block:
  - ack0 and load at cycle 1 with dest=0, nible=C;
  - load at cycle 3 with dest=1, nible=1;
  - busy high cycles 1-4; IDLE at cycle 5.
- req1, byte1=8'h41, WR_GAP=0:
  - loads at cycles 1 and 2 with (dest 2, nible 1) then (dest 3, nible 4);
  - ack1 only at cycle 1.
- req0 and req1 high together after reset:
  - byte0 is written first, then byte1 with no extra idle beyond the IDLE cycle;
  - a third simultaneous request is granted to req0 (alternation).
- Reset asserted during GAP_LO of a byte0=8'hF0 write:
  - no dest=1 write occurs;
  - all outputs 0 the next cycle;
  - a subsequent req0 is granted first.
- byte0 changed from 8'h12 to 8'h34 one cycle after grant: written nibbles are 2 and 1.
- With DISP_CLEAR_ON_RESET_EN and WR_GAP=1:
  - after reset, loads at dest 0,1,2,3 with nible 0, every 2 cycles;
  - a req0 held during the clear receives ack0 only after the clear completes.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display write scheduler: FSM encodings and digit map.
package disp_pkg;

  localparam int NIB_W = 4;
  localparam int DIG_W = 2;

  // Digit pair bases: keyboard path owns digits 1:0, ASCII path owns 3:2.
  localparam logic [DIG_W-1:0] DIG_KEYB  = 2'd0;
  localparam logic [DIG_W-1:0] DIG_ASCII = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_LO    = 3'd1,
    GAP_LO   = 3'd2,
    WR_HI    = 3'd3,
    GAP_HI   = 3'd4,
    CLR_INIT = 3'd5,
    CLR_WR   = 3'd6,
    CLR_GAP  = 3'd7
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant moves only when the grant is taken.
module rr_arb2 (
  input  logic reloj,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant;

  assign grant_valid = req0 | req1;
  // On a tie the requester that did not win last time gets the port.
  assign grant_id = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge reloj) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update && grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/disp_write_sched.sv
// Shares the 4-digit display load port between two byte producers, one nibble per load.
// Optional build macro DISP_CLEAR_ON_RESET_EN: zero all four digits after reset.
module disp_write_sched
  import disp_pkg::*;
#(
  parameter int WR_GAP = 1
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             req0,
  input  logic [7:0]       byte0,
  output logic             ack0,
  input  logic             req1,
  input  logic [7:0]       byte1,
  output logic             ack1,
  output logic             load,
  output logic [DIG_W-1:0] bufdestino,
  output logic [NIB_W-1:0] nible,
  output logic             busy
);

  localparam logic [3:0] GAP_RLD = 4'(WR_GAP);

`ifdef DISP_CLEAR_ON_RESET_EN
  localparam state_e RST_STATE = CLR_INIT;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e           state, state_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic [7:0]       byte_q, byte_n;
  logic             gid_q, gid_n;
  logic             load_n, ack0_n, ack1_n, busy_n;
  logic [DIG_W-1:0] dest_n, base_q;
  logic [NIB_W-1:0] nib_n;
  logic             grant_valid, grant_id, update;
  logic [7:0]       grant_byte;
`ifdef DISP_CLEAR_ON_RESET_EN
  logic [DIG_W-1:0] clr_dig, clr_dig_n;
`endif

  rr_arb2 u_arb (
    .reloj       (reloj),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .update      (update),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign update     = (state == IDLE);
  assign grant_byte = grant_id ? byte1 : byte0;
  assign base_q     = gid_q ? DIG_ASCII : DIG_KEYB;

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    byte_n    = byte_q;
    gid_n     = gid_q;
    load_n    = 1'b0;
    ack0_n    = 1'b0;
    ack1_n    = 1'b0;
    dest_n    = bufdestino;
    nib_n     = nible;
`ifdef DISP_CLEAR_ON_RESET_EN
    clr_dig_n = clr_dig;
`endif
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_n = WR_LO;
          byte_n  = grant_byte;
          gid_n   = grant_id;
          load_n  = 1'b1;
          dest_n  = grant_id ? DIG_ASCII : DIG_KEYB;
          nib_n   = grant_byte[3:0];
          ack0_n  = ~grant_id;
          ack1_n  = grant_id;
        end
      end
      WR_LO: begin
        if (GAP_RLD == 4'd0) begin
          state_n = WR_HI;
        end else begin
          state_n   = GAP_LO;
          gap_cnt_n = GAP_RLD;
        end
      end
      GAP_LO: begin
        gap_cnt_n = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) state_n = WR_HI;
      end
      WR_HI: begin
        if (GAP_RLD == 4'd0) begin
          state_n = IDLE;
        end else begin
          state_n   = GAP_HI;
          gap_cnt_n = GAP_RLD;
        end
      end
      GAP_HI: begin
        gap_cnt_n = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) state_n = IDLE;
      end
`ifdef DISP_CLEAR_ON_RESET_EN
      CLR_INIT: begin
        state_n   = CLR_WR;
        clr_dig_n = 2'd0;
      end
      CLR_WR: begin
        if (GAP_RLD != 4'd0) begin
          state_n   = CLR_GAP;
          gap_cnt_n = GAP_RLD;
        end else if (clr_dig == 2'd3) begin
          state_n = IDLE;
        end else begin
          clr_dig_n = clr_dig + 2'd1;
        end
      end
      CLR_GAP: begin
        gap_cnt_n = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) begin
          if (clr_dig == 2'd3) begin
            state_n = IDLE;
          end else begin
            state_n   = CLR_WR;
            clr_dig_n = clr_dig + 2'd1;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    // WR_HI is never held, so landing in it always means a fresh high-nibble write.
    if (state_n == WR_HI) begin
      load_n = 1'b1;
      dest_n = base_q + 2'd1;
      nib_n  = byte_q[7:4];
    end
`ifdef DISP_CLEAR_ON_RESET_EN
    if (state_n == CLR_WR) begin
      load_n = 1'b1;
      dest_n = clr_dig_n;
      nib_n  = '0;
    end
`endif
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      state      <= RST_STATE;
      gap_cnt    <= '0;
      byte_q     <= '0;
      gid_q      <= 1'b0;
      load       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      bufdestino <= '0;
      nible      <= '0;
      busy       <= 1'b0;
`ifdef DISP_CLEAR_ON_RESET_EN
      clr_dig    <= '0;
`endif
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_cnt_n;
      byte_q     <= byte_n;
      gid_q      <= gid_n;
      load       <= load_n;
      ack0       <= ack0_n;
      ack1       <= ack1_n;
      bufdestino <= dest_n;
      nible      <= nib_n;
      busy       <= busy_n;
`ifdef DISP_CLEAR_ON_RESET_EN
      clr_dig    <= clr_dig_n;
`endif
    end
  end

endmodule
